// File: rtl/piso_74165_pkg.sv
// Shared constants for the 74x165-style parallel-in/serial-out shift register.
package piso_74165_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic RST_VAL = '0;

endpackage

// File: rtl/piso_shift_74165_cell.sv
// One storage bit of the 74x165 register: a flop with async set/clear, as in the
// original part, so that a held parallel load stays transparent to changes on d.
module piso_shift_74165_cell (
  input  logic cp,
  input  logic load_set,
  input  logic load_clr,
  input  logic bit_d,
  output logic bit_q
);

  // The set and clear terms are level-held while n_pl is low, so each d change
  // lands immediately, and the last d value is retained once both fall.
  always_ff @(posedge cp or posedge load_set or posedge load_clr) begin
    if (load_set) begin
      bit_q <= 1'b1;
    end else if (load_clr) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

endmodule

// File: rtl/piso_shift_74165.sv
// 74x165-compatible parallel-in/serial-out shift register with transparent load.
// Optional macro PISO_SHIFT_74165_PAR_OUT_EN adds the parallel observation port q.
module piso_shift_74165
  import piso_74165_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             n_pl,
  input  logic             n_ce,
  input  logic             ds,
  input  logic [WIDTH-1:0] d,
  output logic             q7,
  output logic             n_q7
`ifdef PISO_SHIFT_74165_PAR_OUT_EN
  ,
  output logic [WIDTH-1:0] q
`endif
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] load_set;
  logic [WIDTH-1:0] load_clr;

  // Parallel load overrides every clocked action, including reset.
  assign load_set = {WIDTH{~n_pl}} & d;
  assign load_clr = {WIDTH{~n_pl}} & ~d;

  always_comb begin
    r_d = r_q;
    if (rst) begin
      r_d = {WIDTH{RST_VAL}};
    end else if (!n_ce) begin
      r_d = {r_q[WIDTH-2:0], ds};
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    piso_shift_74165_cell u_cell (
      .cp       (cp),
      .load_set (load_set[i]),
      .load_clr (load_clr[i]),
      .bit_d    (r_d[i]),
      .bit_q    (r_q[i])
    );
  end

  assign q7   = r_q[WIDTH-1];
  assign n_q7 = ~r_q[WIDTH-1];

`ifdef PISO_SHIFT_74165_PAR_OUT_EN
  assign q = r_q;
`endif

endmodule

// File: tb/tb_piso_shift_74165.sv
// Self-checking bench for piso_shift_74165: vector table, corner sequences and a
// randomized run against an arithmetic model of the register.
module tb_piso_shift_74165;

  localparam int W = 8;

  logic         cp;
  logic         rst;
  logic         n_pl;
  logic         n_ce;
  logic         ds;
  logic [W-1:0] d;
  logic         q7;
  logic         n_q7;
`ifdef PISO_SHIFT_74165_PAR_OUT_EN
  logic [W-1:0] q;
`endif

  int tests_run;
  int tests_failed;

  typedef struct {
    logic         n_pl;
    logic         n_ce;
    logic         rst;
    logic         ds;
    logic [W-1:0] d;
    logic         exp_q7;
  } vec_t;

  vec_t vecs[$];

  piso_shift_74165 #(.WIDTH(W)) dut (
    .cp   (cp),
    .rst  (rst),
    .n_pl (n_pl),
    .n_ce (n_ce),
    .ds   (ds),
    .d    (d),
    .q7   (q7),
    .n_q7 (n_q7)
`ifdef PISO_SHIFT_74165_PAR_OUT_EN
    ,
    .q    (q)
`endif
  );

  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic exp_q7);
    tests_run++;
    if (q7 !== exp_q7 || n_q7 !== ~exp_q7) begin
      tests_failed++;
      $display("[TB] FAIL %s: got q7=%b n_q7=%b, want q7=%b n_q7=%b",
               name, q7, n_q7, exp_q7, ~exp_q7);
    end
  endtask

`ifdef PISO_SHIFT_74165_PAR_OUT_EN
  task automatic checkPar(input string name, input logic [W-1:0] exp_q);
    tests_run++;
    if (q !== exp_q) begin
      tests_failed++;
      $display("[TB] FAIL %s: got q=%h, want q=%h", name, q, exp_q);
    end
  endtask
`endif

  // Drives the clocked inputs now, then returns 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic ce_n, input logic rst_v, input logic ds_v);
    n_ce = ce_n;
    rst  = rst_v;
    ds   = ds_v;
    @(posedge cp);
    #1;
  endtask

  // Pulses the parallel load while cp is low, never coincident with an edge.
  task automatic loadValue(input logic [W-1:0] v);
    @(negedge cp);
    #1;
    n_pl = 1'b0;
    d    = v;
    #2;
    n_pl = 1'b1;
  endtask

  logic [W-1:0] model;
  logic [W-1:0] rnd;
  int           op;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst  = 1'b0;
    n_pl = 1'b1;
    n_ce = 1'b1;
    ds   = 1'b0;
    d    = '0;

    // Transparent load with cp low, then with cp high.
    @(negedge cp);
    #1;
    n_pl = 1'b0;
    d    = 8'hA5;
    #1 checkOutput("load_cp0_a5", 1'b1);
    d = 8'h5A;
    #1 checkOutput("load_cp0_5a", 1'b0);
    @(posedge cp);
    #1;
    d = 8'hA5;
    #1 checkOutput("load_cp1_a5", 1'b1);
    d = 8'h5A;
    #1 checkOutput("load_cp1_5a", 1'b0);

    // Load 0x5A then shift: ds=0 at edge 1, ds=1 afterwards.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1});

    @(negedge cp);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      n_pl = vecs[i].n_pl;
      d    = vecs[i].d;
      applyStimulus(vecs[i].n_ce, vecs[i].rst, vecs[i].ds);
      checkOutput($sformatf("vec%0d_rise", i), vecs[i].exp_q7);
      @(negedge cp);
      #1 checkOutput($sformatf("vec%0d_fall", i), vecs[i].exp_q7);
    end

    // Enable hold.
    n_ce = 1'b1;
    loadValue(8'h80);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("hold_%0d", i), 1'b1);
    end
    @(negedge cp);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_release_shift", 1'b0);

    // Synchronous reset, and reset ignored during load.
    n_ce = 1'b1;
    loadValue(8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("reset_edge", 1'b0);
    @(negedge cp);
    #1;
    n_pl = 1'b0;
    d    = 8'hFF;
    #1 checkOutput("reset_vs_load_now", 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("reset_vs_load_edge", 1'b1);
    @(negedge cp);
    #1;
    n_pl = 1'b1;
    rst  = 1'b0;

    // Load beats shift at a rising edge.
    @(negedge cp);
    #1;
    n_pl = 1'b0;
    d    = 8'h01;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("load_priority", 1'b0);
    @(negedge cp);
    #1;
    n_pl = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge cp);
      #1;
    end
    checkOutput("load_priority_7_shifts", 1'b1);

`ifdef PISO_SHIFT_74165_PAR_OUT_EN
    n_ce = 1'b1;
    loadValue(8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkPar("par_out_shift", 8'hB5);
`endif

    // Randomized run against the model register.
    n_ce = 1'b1;
    rst  = 1'b0;
    loadValue(8'h00);
    model = 8'h00;
    for (int it = 0; it < 300; it++) begin
      @(negedge cp);
      #1;
      op = int'($urandom_range(0, 3));
      if (op == 0) begin
        n_pl = 1'b0;
        rnd  = 8'($urandom);
        d    = rnd;
        model = rnd;
        #1 checkOutput("rand_load", model[W-1]);
        rnd  = 8'($urandom);
        d    = rnd;
        model = rnd;
        #1 checkOutput("rand_load_change", model[W-1]);
        n_pl = 1'b1;
        d    = 8'($urandom);
        #1 checkOutput("rand_load_retain", model[W-1]);
      end
      d = 8'($urandom);
      applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                    1'($urandom));
      if (rst) begin
        model = '0;
      end else if (!n_ce) begin
        model = (model << 1) | W'(ds);
      end
      checkOutput("rand_edge", model[W-1]);
`ifdef PISO_SHIFT_74165_PAR_OUT_EN
      checkPar("rand_par", model);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
